// File: rtl/pintar_pkg.sv
// rtl/pintar_pkg.sv - colour codes, screen/road geometry and pixel widths for the sprite painter
package pintar_pkg;

   typedef enum logic [2:0] {
      C_FONDO = 3'd0,
      C_OBST  = 3'd1,
      C_BORDE = 3'd3,
      C_JUG   = 3'd7
   } color_e;

   localparam int PX_W       = 11;
   localparam int POSX_W     = 10;
   localparam int POSY_W     = 9;

   localparam int DEF_SPR_W  = 85;
   localparam int DEF_SPR_H  = 90;
   localparam int DEF_SCR_W  = 640;
   localparam int DEF_SCR_H  = 480;
   localparam int DEF_ROAD_L = 215;
   localparam int DEF_ROAD_R = 425;
   localparam int DEF_Y_JUG  = 340;

endpackage

// File: rtl/sprite_hit.sv
// rtl/sprite_hit.sv - combinational rectangle hit test with vertical wrap below the screen bottom
module sprite_hit
   import pintar_pkg::*;
#(
   parameter int W      = DEF_SPR_W,
   parameter int H      = DEF_SPR_H,
   parameter int WRAP_H = DEF_SCR_H
) (
   input  logic [PX_W-1:0] i_px,
   input  logic [PX_W-1:0] i_py,
   input  logic [PX_W-1:0] i_x,
   input  logic [PX_W-1:0] i_y,
   output logic            o_hit
);

   logic [PX_W-1:0] w_x_end;
   logic [PX_W-1:0] w_y_end;
   logic            w_in_x;
   logic            w_in_y;
   logic            w_in_wrap;

   assign w_x_end = i_x + PX_W'(W);
   assign w_y_end = i_y + PX_W'(H);

   assign w_in_x = (i_px >= i_x) && (i_px < w_x_end);
   assign w_in_y = (i_py >= i_y) && (i_py < w_y_end);

   // The part of the sprite hanging below the last row reappears at the top.
   assign w_in_wrap = (w_y_end > PX_W'(WRAP_H)) && (i_py < (w_y_end - PX_W'(WRAP_H)));

   assign o_hit = w_in_x && (w_in_y || w_in_wrap);

endmodule

// File: rtl/pintar_sprites.sv
// rtl/pintar_sprites.sv - frame-synchronous sprite painter with 2-stage colour pipe and per-frame collisions
module pintar_sprites
   import pintar_pkg::*;
#(
   parameter int N_OBST  = 3,
   parameter int COLOR_W = 3,
   parameter int SPR_W   = DEF_SPR_W,
   parameter int SPR_H   = DEF_SPR_H,
   parameter int SCR_W   = DEF_SCR_W,
   parameter int SCR_H   = DEF_SCR_H,
   parameter int ROAD_L  = DEF_ROAD_L,
   parameter int ROAD_R  = DEF_ROAD_R,
   parameter int Y_JUG   = DEF_Y_JUG
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [10:0]                pixelX,
   input  logic [9:0]                 pixelY,
   input  logic                       iVideoOn,
   input  logic                       iFinCuadro,
   input  logic                       iPintarCarros,
   input  logic                       iPintarJugador,
   input  logic [N_OBST*POSX_W-1:0]   iPosicionX,
   input  logic [N_OBST*POSY_W-1:0]   iPosicionY,
   input  logic [POSX_W-1:0]          iPosicionJugador,
   output logic [COLOR_W-1:0]         oColorRGB,
   output logic                       oColision,
   output logic                       oColisionBorde,
   output logic [N_OBST-1:0]          oColisionId
);

   logic [N_OBST*POSX_W-1:0] r_pos_x;
   logic [N_OBST*POSY_W-1:0] r_pos_y;
   logic [POSX_W-1:0]        r_pos_jug;
   logic                     r_en_carros;
   logic                     r_en_jug;

   logic [N_OBST+1:0]        r_s1_hits;
   logic                     r_s1_von;
   logic [COLOR_W-1:0]       r_color;

   logic [N_OBST-1:0]        r_acc_obs;
   logic                     r_acc_bor;
   logic [N_OBST-1:0]        r_col_id;
   logic                     r_col_bor;
   logic                     r_colision;

   logic [PX_W-1:0]          w_px;
   logic [PX_W-1:0]          w_py;
   logic [N_OBST-1:0]        w_hit_obs;
   logic                     w_hit_jug;
   logic                     w_hit_bor;

   logic                     w_s2_jug;
   logic [N_OBST-1:0]        w_s2_obs;
   logic                     w_s2_bor;
   logic [N_OBST-1:0]        w_col_obs;
   logic                     w_col_bor;
   logic [N_OBST-1:0]        w_pub_obs;
   logic [COLOR_W-1:0]       w_color;

   assign w_px = pixelX;
   assign w_py = {1'b0, pixelY};

   // Hit tests look only at the shadow copies so a frame is painted from one consistent snapshot.
   for (genvar g = 0; g < N_OBST; g++) begin : g_obs
      sprite_hit #(.W(SPR_W), .H(SPR_H), .WRAP_H(SCR_H)) u_hit (
         .i_px  (w_px),
         .i_py  (w_py),
         .i_x   ({1'b0, r_pos_x[POSX_W*g +: POSX_W]}),
         .i_y   ({2'b00, r_pos_y[POSY_W*g +: POSY_W]}),
         .o_hit (w_hit_obs[g])
      );
   end

   sprite_hit #(.W(SPR_W), .H(SPR_H), .WRAP_H(SCR_H)) u_hit_jug (
      .i_px  (w_px),
      .i_py  (w_py),
      .i_x   ({1'b0, r_pos_jug}),
      .i_y   (PX_W'(Y_JUG)),
      .o_hit (w_hit_jug)
   );

   assign w_hit_bor = ((w_px < PX_W'(ROAD_L)) || ((w_px >= PX_W'(ROAD_R)) && (w_px < PX_W'(SCR_W))))
                      && (w_py < PX_W'(SCR_H));

   assign w_s2_jug = r_s1_hits[N_OBST+1] & r_en_jug & r_s1_von;
   assign w_s2_obs = r_s1_hits[N_OBST:1] & {N_OBST{r_en_carros & r_s1_von}};
   assign w_s2_bor = r_s1_hits[0] & r_en_carros & r_s1_von;

   assign w_col_obs = w_s2_obs & {N_OBST{w_s2_jug}};
   assign w_col_bor = w_s2_bor & w_s2_jug;
   assign w_pub_obs = r_acc_obs | w_col_obs;

   always_comb begin
      w_color = COLOR_W'(C_FONDO);
      if (w_s2_jug) begin
         w_color = COLOR_W'(C_JUG);
      end else if (|w_s2_obs) begin
         w_color = COLOR_W'(C_OBST);
      end else if (w_s2_bor) begin
         w_color = COLOR_W'(C_BORDE);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pos_x     <= '0;
         r_pos_y     <= '0;
         r_pos_jug   <= '0;
         r_en_carros <= 1'b0;
         r_en_jug    <= 1'b0;
         r_s1_hits   <= '0;
         r_s1_von    <= 1'b0;
         r_color     <= COLOR_W'(C_FONDO);
         r_acc_obs   <= '0;
         r_acc_bor   <= 1'b0;
         r_col_id    <= '0;
         r_col_bor   <= 1'b0;
         r_colision  <= 1'b0;
      end else begin
         r_s1_hits <= {w_hit_jug, w_hit_obs, w_hit_bor};
         r_s1_von  <= iVideoOn;
         r_color   <= w_color;
         if (iFinCuadro) begin
            r_pos_x     <= iPosicionX;
            r_pos_y     <= iPosicionY;
            r_pos_jug   <= iPosicionJugador;
            r_en_carros <= iPintarCarros;
            r_en_jug    <= iPintarJugador;
            // The pixel leaving stage 2 on this edge still belongs to the frame being closed.
            r_col_id    <= w_pub_obs;
            r_col_bor   <= r_acc_bor | w_col_bor;
            r_colision  <= |w_pub_obs;
            r_acc_obs   <= '0;
            r_acc_bor   <= 1'b0;
         end else begin
            r_acc_obs <= w_pub_obs;
            r_acc_bor <= r_acc_bor | w_col_bor;
         end
      end
   end

   assign oColorRGB      = r_color;
   assign oColision      = r_colision;
   assign oColisionBorde = r_col_bor;
   assign oColisionId    = r_col_id;

endmodule

// File: tb/tb_pintar_sprites.sv
// tb/tb_pintar_sprites.sv - directed and randomized checks of pintar_sprites against a geometric model
module tb_pintar_sprites;

   localparam int N = 3;

   logic          clk;
   logic          reset;
   logic [10:0]   pixelX;
   logic [9:0]    pixelY;
   logic          iVideoOn;
   logic          iFinCuadro;
   logic          iPintarCarros;
   logic          iPintarJugador;
   logic [N*10-1:0] iPosicionX;
   logic [N*9-1:0]  iPosicionY;
   logic [9:0]    iPosicionJugador;
   logic [2:0]    oColorRGB;
   logic          oColision;
   logic          oColisionBorde;
   logic [N-1:0]  oColisionId;

   pintar_sprites #(.N_OBST(N), .COLOR_W(3)) dut (
      .clk              (clk),
      .reset            (reset),
      .pixelX           (pixelX),
      .pixelY           (pixelY),
      .iVideoOn         (iVideoOn),
      .iFinCuadro       (iFinCuadro),
      .iPintarCarros    (iPintarCarros),
      .iPintarJugador   (iPintarJugador),
      .iPosicionX       (iPosicionX),
      .iPosicionY       (iPosicionY),
      .iPosicionJugador (iPosicionJugador),
      .oColorRGB        (oColorRGB),
      .oColision        (oColision),
      .oColisionBorde   (oColisionBorde),
      .oColisionId      (oColisionId)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_fail = 0;
   int n_tot  = 0;

   // values the bench is driving onto the position/enable inputs
   int ox[N];
   int oy[N];
   int jx;
   bit enc;
   bit enj;

   // model of the snapshot the design should be painting with
   int sx[N];
   int sy[N];
   int sjx;
   bit sen_c;
   bit sen_j;
   logic [N-1:0] m_acc;
   logic         m_acc_bor;
   logic [N-1:0] m_out;
   logic         m_out_bor;

   function automatic bit rect_hit(int x, int y, int px, int py);
      bit in_x = (px >= x) && (px < x + 85);
      bit in_y = (py >= y) && (py < y + 90);
      bit wrap = (y + 90 > 480) && (py < y + 90 - 480);
      return in_x && (in_y || wrap);
   endfunction

   function automatic bit border_hit(int px, int py);
      return ((px < 215) || (px >= 425 && px < 640)) && (py < 480);
   endfunction

   function automatic int model_color(int px, int py, bit von);
      if (!von) return 0;
      if (sen_j && rect_hit(sjx, 340, px, py)) return 7;
      if (sen_c) begin
         for (int i = 0; i < N; i++)
            if (rect_hit(sx[i], sy[i], px, py)) return 1;
         if (border_hit(px, py)) return 3;
      end
      return 0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_tot++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic drive_pos();
      for (int i = 0; i < N; i++) begin
         iPosicionX[10*i +: 10] = 10'(ox[i]);
         iPosicionY[9*i +: 9]   = 9'(oy[i]);
      end
      iPosicionJugador = 10'(jx);
      iPintarCarros    = enc;
      iPintarJugador   = enj;
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         sx[i] = 0;
         sy[i] = 0;
      end
      sjx = 0; sen_c = 0; sen_j = 0;
      m_acc = '0; m_acc_bor = 0; m_out = '0; m_out_bor = 0;
   endtask

   task automatic model_latch();
      for (int i = 0; i < N; i++) begin
         sx[i] = ox[i];
         sy[i] = oy[i];
      end
      sjx = jx; sen_c = enc; sen_j = enj;
   endtask

   task automatic chk_coll(string tag);
      chk({tag, "_id"}, oColisionId, m_out);
      chk({tag, "_bor"}, oColisionBorde, m_out_bor);
      chk({tag, "_col"}, oColision, |m_out);
   endtask

   // exp_spec < 0 means only the model is consulted
   task automatic paint(string tag, int px, int py, bit von, int exp_spec);
      pixelX = 11'(px);
      pixelY = 10'(py);
      iVideoOn = von;
      tick();
      tick();
      if (exp_spec >= 0) chk({tag, "_spec"}, oColorRGB, exp_spec);
      chk(tag, oColorRGB, model_color(px, py, von));
      if (von && sen_j && rect_hit(sjx, 340, px, py)) begin
         for (int i = 0; i < N; i++)
            if (sen_c && rect_hit(sx[i], sy[i], px, py)) m_acc[i] = 1'b1;
         if (sen_c && border_hit(px, py)) m_acc_bor = 1'b1;
      end
   endtask

   task automatic frame(string tag, int pulses);
      iVideoOn = 1'b0;
      tick();
      tick();
      drive_pos();
      iFinCuadro = 1'b1;
      for (int k = 0; k < pulses; k++) tick();
      iFinCuadro = 1'b0;
      model_latch();
      m_out     = (pulses == 1) ? m_acc : '0;
      m_out_bor = (pulses == 1) ? m_acc_bor : 1'b0;
      m_acc = '0;
      m_acc_bor = 1'b0;
      chk_coll(tag);
   endtask

   initial begin
      reset = 1'b1;
      pixelX = '0; pixelY = '0; iVideoOn = 1'b0; iFinCuadro = 1'b0;
      for (int i = 0; i < N; i++) begin
         ox[i] = 0;
         oy[i] = 0;
      end
      jx = 0; enc = 0; enj = 0;
      drive_pos();
      model_reset();

      // reset held while pixels, positions and frame pulses toggle
      for (int c = 0; c < 16; c++) begin
         pixelX = 11'($urandom_range(0, 700));
         pixelY = 10'($urandom_range(0, 500));
         iVideoOn = 1'b1;
         iFinCuadro = 1'($urandom_range(0, 1));
         iPosicionX = N*10'($urandom);
         iPintarCarros = 1'b1;
         iPintarJugador = 1'b1;
         tick();
         chk("rst_color", oColorRGB, 0);
         chk("rst_col", {oColision, oColisionBorde, oColisionId}, 0);
      end
      iFinCuadro = 1'b0;
      drive_pos();
      reset = 1'b0;

      // first frame paints from zeroed shadows with everything disabled
      paint("first_frame", 100, 60, 1, 0);

      ox = '{230, 600, 600};
      oy = '{100, 200, 200};
      jx = 0; enc = 1; enj = 0;
      frame("f1", 1);
      paint("t2_hit", 230, 100, 1, 1);
      paint("t2_xedge", 315, 100, 1, 0);
      paint("t2_yedge", 230, 190, 1, 0);

      ox[1] = 300; oy[1] = 450;
      frame("f2", 1);
      paint("t3_r450", 300, 450, 1, 1);
      paint("t3_r479", 300, 479, 1, 1);
      paint("t3_r0", 300, 0, 1, 1);
      paint("t3_r59", 300, 59, 1, 1);
      paint("t3_r60", 300, 60, 1, 0);
      paint("t3_border", 100, 60, 1, 3);

      jx = 230; enj = 1; ox[2] = 250; oy[2] = 300;
      frame("f3", 1);
      paint("t4_player", 260, 350, 1, 7);
      frame("f4", 1);
      chk("t4_id_spec", oColisionId, 3'b100);
      chk("t4_col_spec", oColision, 1);
      frame("f4_empty", 1);
      chk("t4_clear_spec", oColision, 0);

      jx = 150;
      frame("f5", 1);
      paint("bor_player", 160, 350, 1, 7);
      frame("f6", 1);
      chk("bor_spec", oColisionBorde, 1);

      // positions change mid-frame but the snapshot must hold
      paint("t5_before", 230, 100, 1, 1);
      ox[0] = 400;
      drive_pos();
      paint("t5_old_pos", 230, 100, 1, 1);
      paint("t5_new_not_yet", 400, 100, 1, 0);
      frame("f7", 1);
      paint("t5_old_gone", 230, 100, 1, 0);
      paint("t5_new_shown", 400, 100, 1, 1);
      paint("t5_bor_hit", 200, 350, 1, 7);
      frame("f8_b2b", 2);
      chk("b2b_spec", {oColision, oColisionBorde, oColisionId}, 0);

      jx = 230;
      frame("f9", 1);
      paint("t6_vid_off", 260, 350, 0, 0);
      frame("f10", 1);
      chk("t6_nocol_spec", oColision, 0);
      enc = 0;
      frame("f11", 1);
      paint("t6_obst_off", 400, 100, 1, 0);
      paint("t6_player_on", 260, 350, 1, 7);
      paint("t6_border_off", 100, 60, 1, 0);
      frame("f12", 1);

      // randomized frames
      for (int f = 0; f < 8; f++) begin
         for (int i = 0; i < N; i++) begin
            ox[i] = $urandom_range(0, 1023);
            oy[i] = $urandom_range(0, 511);
         end
         jx = $urandom_range(0, 600);
         enc = ($urandom_range(0, 3) != 0);
         enj = ($urandom_range(0, 3) != 0);
         frame("rnd_frame", 1);
         for (int p = 0; p < 30; p++) begin
            if (p[0])
               paint("rnd_pix", $urandom_range(0, 700), $urandom_range(0, 520),
                     1'($urandom_range(0, 7) != 0), -1);
            else
               paint("rnd_pix", sjx + $urandom_range(0, 90), $urandom_range(335, 435),
                     1'($urandom_range(0, 7) != 0), -1);
         end
      end
      frame("rnd_last", 1);

      // reset in the middle of a frame with a collision pending
      enc = 1; enj = 1; jx = 230; ox[2] = 250; oy[2] = 300;
      frame("f13", 1);
      paint("mid_rst_pix", 260, 350, 1, 7);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
      chk("mid_rst_color", oColorRGB, 0);
      chk_coll("mid_rst");
      frame("f14", 1);
      chk("mid_rst_nopub_spec", oColisionId, 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
